pwm_speed_ramp: RTL and testbench
=================================

# pwm_speed_ramp

Soft-start/soft-stop controller that sits directly upstream of the PWM generator. It drives the generator's 3-bit speed level and enable from the raw run, target and halt pins. Speed changes are stepped one level at a time at a programmable rate, so the load never sees a duty-cycle jump larger than one level. All pin inputs are synchronised inside the block; all outputs are registered.

## Interface
- `RAMP_DIV`, default 1_000_000: clock cycles per one-level speed step. Legal range ≥ 2.
- `clock`  in  1: system clock. All state is updated on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `run`  in  1: async pin. 1 = request the load running.
- `target`  in  3: async pin bus giving the requested speed level 0..7. Quasi-static: it must be held for at least 3 cycles.
- `halt`  in  1: async pin, emergency stop. Level-sensitive; overrides everything else.
- `speed`  out  3: current speed level. Connects to the PWM generator speed input.
- `enable`  out  1: PWM generator enable.
- `busy`  out  1: high while a ramp is in progress.

## Operation
- Synchronisers:
  - `run`, `target` and `halt` each pass through 2 flops, producing `run_s`, `target_s` and `halt_s`.
  - All decisions use only the synchronised values.
- Goal level: `goal = run_s ? target_s : 0`, re-evaluated every cycle.
- Registered level: `cur` (3 bits), driven directly onto `speed`.
- State machine states: IDLE, RAMP, RUN. Transitions:
  - Any state with `halt_s`=1 → IDLE and `cur`=0. `halt_s` has priority over every other transition. While `halt_s`=1 the block stays in IDLE.
  - IDLE → RAMP when `run_s`=1 and `target_s`≠0. Otherwise the block stays in IDLE with `cur`=0.
  - RAMP:
    - On each prescaler tick, `cur` moves one step toward `goal` (+1 if `cur`<`goal`, −1 if `cur`>`goal`).
    - Direction is re-evaluated at every tick, so a mid-ramp change of goal reverses the ramp.
    - When `cur`==`goal` (checked every cycle): goal≠0 → RUN; goal==0 → IDLE.
  - RUN → RAMP when `goal`≠`cur`.
- Prescaler:
  - Counts 0..RAMP_DIV−1, but only while in RAMP.
  - Cleared to 0 on every entry into RAMP and whenever the state is not RAMP.
  - A tick occurs on the cycle the count equals RAMP_DIV−1; the count then wraps to 0.
  - Width is `$clog2(RAMP_DIV)`.
- Arithmetic:
  - `cur` never leaves the range 0..7; no wrap-around is possible, because the step is always toward a legal goal.
  - The prescaler compare is unsigned.
- Outputs:
  - `enable` = registered (next state ≠ IDLE).
  - `busy` = registered (next state == RAMP).
  - `speed` = `cur`.
- Reset values: `speed`=0, `enable`=0, `busy`=0, state IDLE, prescaler 0, all synchroniser flops 0. Asserting `reset` mid-ramp forces these values immediately, without waiting for a clock edge.

## Timing
- Pin to synchronised value: 2 edges.
- `run` rises with `target`≠0 at edge 0 → RAMP entered, and `enable`=1 and `busy`=1, at edge 3.
- First step occurs RAMP_DIV edges after RAMP entry; each subsequent step is RAMP_DIV edges later.
- A full 0→7 ramp takes 7·RAMP_DIV edges.
- When `cur` reaches `goal`, the state (and `busy`) changes on the next edge. When the goal is 0, `enable` falls on that same next edge.
- `halt` pin rise → `speed`=0 and `enable`=0 at edge 3.
- Simultaneous events: a goal change and a tick in the same cycle → the step uses the new goal.

## Structure
- Package `pwm_pkg` holds:
  - the `speed_t` typedef (logic [2:0]);
  - `SPEED_MAX` = 3'd7;
  - the state enum `ramp_state_t` {IDLE, RAMP, RUN}.
- Sub-module `sync_2ff` (parameter WIDTH), instantiated once per input group (width 1, 3 and 1).
- The prescaler and state machine live in the top body. The prescaler is not split into a separate module.

## Test plan
All scenarios run with RAMP_DIV=4.
- Scenario 1, start-up ramp: `reset` pulse, then `run`=1 with `target`=5 → `enable`=`busy`=1 at edge 3. `speed` then steps 1,2,3,4,5 at edges 7,11,15,19,23. `busy` falls at edge 24 and `enable` stays 1.
- Scenario 2, ramp down: from RUN at 5, drop `run` → `speed` steps 4..0 at 4-cycle intervals. `enable` and `busy` fall on the edge after `speed`=0.
- Scenario 3, mid-ramp reversal: `target`=7, then when `speed`=3 set `target`=1 → `speed` goes 2, then 1, then the block enters RUN with `busy`=0. At no point does `speed` exceed 3.
- Scenario 4, halt during RUN: `halt` rises during RUN at speed 6 → `speed`=0 and `enable`=0 at edge 3. While `halt` is held with `run`=1, the block stays IDLE. After `halt` is released, a fresh ramp starts from 0.
- Scenario 5, zero target: `run`=1 with `target`=0 → `enable`, `busy` and `speed` remain 0 indefinitely.
- Scenario 6, asynchronous reset mid-ramp: assert `reset` between clock edges at `speed`=4 → all outputs are 0 before the next edge. After release, with `run` still high, the 3-edge restart latency applies.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the soft-start/soft-stop speed ramp in front of the PWM generator.
package pwm_pkg;

   typedef logic [2:0] speed_t;

   localparam speed_t SPEED_MAX = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      RUN  = 2'd2
   } ramp_state_t;

endpackage

// File: rtl/pwm_speed_ramp_if.sv
// Pin-level bundle between the pin drivers (master) and the speed ramp block (slave).
interface pwm_speed_ramp_if;
   import pwm_pkg::*;

   // Plain level signals, no valid/ready handshake: run/target/halt are asynchronous
   // pins sampled continuously, and speed/enable/busy are registered levels that are
   // valid on every cycle.
   logic   run;
   speed_t target;
   logic   halt;
   speed_t speed;
   logic   enable;
   logic   busy;

   modport master (output run, output target, output halt,
                   input  speed, input enable, input busy);

   modport slave  (input  run, input target, input halt,
                   output speed, output enable, output busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin group; reset clears both stages.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pwm_speed_ramp.sv
// Steps the PWM speed level one level per RAMP_DIV cycles toward the requested goal,
// with a synchronised, level-sensitive halt that drops straight to zero.
module pwm_speed_ramp
   import pwm_pkg::*;
#(
   parameter int RAMP_DIV = 1_000_000
) (
   input  logic            clock,
   input  logic            reset,
   pwm_speed_ramp_if.slave pins,
   output ramp_state_t     state_o
);

   localparam int CW = $clog2(RAMP_DIV);

   logic   run_s;
   logic   halt_s;
   speed_t target_s;
   speed_t goal;

   sync_2ff #(.WIDTH(1)) u_sync_run (
      .clock (clock), .reset (reset), .d_i (pins.run), .q_o (run_s)
   );

   sync_2ff #(.WIDTH(3)) u_sync_target (
      .clock (clock), .reset (reset), .d_i (pins.target), .q_o (target_s)
   );

   sync_2ff #(.WIDTH(1)) u_sync_halt (
      .clock (clock), .reset (reset), .d_i (pins.halt), .q_o (halt_s)
   );

   ramp_state_t   state_q, state_d;
   speed_t        cur_q, cur_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          enable_q;
   logic          busy_q;
   logic          tick;

   assign goal = run_s ? target_s : '0;
   assign tick = (state_q == RAMP) && (cnt_q == CW'(RAMP_DIV - 1));

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      if (halt_s) begin
         state_d = IDLE;
         cur_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cur_d = '0;
               if (run_s && (target_s != '0)) state_d = RAMP;
            end
            RAMP: begin
               // Arrival wins over a coincident tick; direction is re-read on every tick.
               if (cur_q == goal) begin
                  state_d = (goal != '0) ? RUN : IDLE;
               end else if (tick) begin
                  cur_d = (cur_q < goal) ? cur_q + 3'd1 : cur_q - 3'd1;
               end
            end
            RUN: begin
               if (goal != cur_q) state_d = RAMP;
            end
            default: begin
               state_d = IDLE;
               cur_d   = '0;
            end
         endcase
      end

      // Prescaler only runs while staying in RAMP, so every RAMP entry starts from 0.
      cnt_d = '0;
      if ((state_q == RAMP) && (state_d == RAMP) && !tick) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         cnt_q    <= '0;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         enable_q <= (state_d != IDLE);
         busy_q   <= (state_d == RAMP);
      end
   end

   assign pins.speed  = cur_q;
   assign pins.enable = enable_q;
   assign pins.busy   = busy_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_pwm_speed_ramp.sv
// Bench for pwm_speed_ramp with RAMP_DIV=4: directed edge-timed scenarios plus a
// randomized pin run checked against a cycle-level model of the ramp rules.
module tb_pwm_speed_ramp;
   import pwm_pkg::*;

   localparam int DIV = 4;

   logic        clock;
   logic        reset;
   ramp_state_t state_dbg;
   int          n_cmp  = 0;
   int          n_fail = 0;

   pwm_speed_ramp_if pins ();

   pwm_speed_ramp #(.RAMP_DIV(DIV)) dut (
      .clock   (clock),
      .reset   (reset),
      .pins    (pins),
      .state_o (state_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: pins delayed two edges, then mode 0=stopped, 1=ramping, 2=holding.
   int m_run_m, m_run_s, m_halt_m, m_halt_s, m_tgt_m, m_tgt_s;
   int m_speed, m_ticks, m_mode;

   task automatic model_clear();
      m_run_m = 0; m_run_s = 0; m_halt_m = 0; m_halt_s = 0;
      m_tgt_m = 0; m_tgt_s = 0; m_speed = 0; m_ticks = 0; m_mode = 0;
   endtask

   task automatic model_edge();
      int goal;
      goal = (m_run_s != 0) ? m_tgt_s : 0;
      if (m_halt_s != 0) begin
         m_mode  = 0;
         m_speed = 0;
      end else if (m_mode == 0) begin
         m_speed = 0;
         if (m_run_s != 0 && m_tgt_s != 0) begin
            m_mode  = 1;
            m_ticks = 0;
         end
      end else if (m_mode == 1) begin
         if (m_speed == goal) begin
            m_mode = (goal != 0) ? 2 : 0;
         end else begin
            m_ticks++;
            if (m_ticks == DIV) begin
               m_ticks = 0;
               m_speed += (goal > m_speed) ? 1 : -1;
            end
         end
      end else if (m_speed != goal) begin
         m_mode  = 1;
         m_ticks = 0;
      end
      m_run_s  = m_run_m;  m_run_m  = int'(pins.run);
      m_halt_s = m_halt_m; m_halt_m = int'(pins.halt);
      m_tgt_s  = m_tgt_m;  m_tgt_m  = int'(pins.target);
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) model_clear();
      else       model_edge();
   end

   task automatic adv(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic do_reset();
      pins.run = 1'b0; pins.target = 3'd0; pins.halt = 1'b0;
      #2 reset = 1'b1;
      adv(2);
      reset = 1'b0;
      adv(2);
   endtask

   task automatic test_reset();
      pins.run = 1'b0; pins.target = 3'd0; pins.halt = 1'b0;
      reset = 1'b1;
      adv(2);
      n_cmp++; if (pins.speed !== 3'd0) begin n_fail++; $display("FAIL reset_speed got=%0d exp=0", pins.speed); end
      n_cmp++; if (pins.enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%0b exp=0", pins.enable); end
      n_cmp++; if (pins.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", pins.busy); end
      n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
      reset = 1'b0;
      adv(3);
      n_cmp++; if (pins.speed !== 3'd0 || pins.enable !== 1'b0 || pins.busy !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_idle got=%0d/%0b/%0b exp=0/0/0", pins.speed, pins.enable, pins.busy);
      end
   endtask

   task automatic test_startup();
      int es, d;
      logic ee, eb;
      pins.run = 1'b1; pins.target = 3'd5;
      for (int e = 1; e <= 26; e++) begin
         adv(1);
         d  = (e - 3) / 4;
         es = (e < 7) ? 0 : ((d > 5) ? 5 : d);
         ee = (e >= 3);
         eb = (e >= 3) && (e < 24);
         n_cmp++; if (pins.speed !== 3'(es)) begin n_fail++; $display("FAIL startup_speed e=%0d got=%0d exp=%0d", e, pins.speed, es); end
         n_cmp++; if (pins.enable !== ee) begin n_fail++; $display("FAIL startup_enable e=%0d got=%0b exp=%0b", e, pins.enable, ee); end
         n_cmp++; if (pins.busy !== eb) begin n_fail++; $display("FAIL startup_busy e=%0d got=%0b exp=%0b", e, pins.busy, eb); end
      end
   endtask

   task automatic test_ramp_down();
      int es, d;
      logic ee, eb;
      pins.run = 1'b0;
      for (int e = 1; e <= 26; e++) begin
         adv(1);
         d  = (e - 3) / 4;
         es = (e < 7) ? 5 : ((5 - d < 0) ? 0 : 5 - d);
         ee = (e < 24);
         eb = (e >= 3) && (e < 24);
         n_cmp++; if (pins.speed !== 3'(es)) begin n_fail++; $display("FAIL down_speed e=%0d got=%0d exp=%0d", e, pins.speed, es); end
         n_cmp++; if (pins.enable !== ee) begin n_fail++; $display("FAIL down_enable e=%0d got=%0b exp=%0b", e, pins.enable, ee); end
         n_cmp++; if (pins.busy !== eb) begin n_fail++; $display("FAIL down_busy e=%0d got=%0b exp=%0b", e, pins.busy, eb); end
      end
   endtask

   task automatic test_reversal();
      int es;
      logic eb;
      logic found;
      pins.run = 1'b1; pins.target = 3'd7;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         adv(1);
         if (pins.speed == 3'd3) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_fail++; $display("FAIL reversal_reach3 got=%0d exp=3", pins.speed); end
      pins.target = 3'd1;
      for (int e = 1; e <= 14; e++) begin
         adv(1);
         es = (e < 4) ? 3 : ((e < 8) ? 2 : 1);
         eb = (e < 9);
         n_cmp++; if (pins.speed !== 3'(es)) begin n_fail++; $display("FAIL reversal_speed e=%0d got=%0d exp=%0d", e, pins.speed, es); end
         n_cmp++; if (pins.busy !== eb) begin n_fail++; $display("FAIL reversal_busy e=%0d got=%0b exp=%0b", e, pins.busy, eb); end
         n_cmp++; if (pins.enable !== 1'b1) begin n_fail++; $display("FAIL reversal_enable e=%0d got=%0b exp=1", e, pins.enable); end
      end
   endtask

   task automatic test_halt();
      int es;
      logic ee;
      logic found;
      pins.target = 3'd6;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         adv(1);
         if (pins.speed == 3'd6 && pins.busy == 1'b0) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_fail++; $display("FAIL halt_reach6 got=%0d exp=6", pins.speed); end
      pins.halt = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         adv(1);
         es = (e < 3) ? 6 : 0;
         ee = (e < 3);
         n_cmp++; if (pins.speed !== 3'(es)) begin n_fail++; $display("FAIL halt_speed e=%0d got=%0d exp=%0d", e, pins.speed, es); end
         n_cmp++; if (pins.enable !== ee) begin n_fail++; $display("FAIL halt_enable e=%0d got=%0b exp=%0b", e, pins.enable, ee); end
      end
      for (int e = 0; e < 20; e++) begin
         adv(1);
         n_cmp++; if (pins.speed !== 3'd0 || pins.enable !== 1'b0 || pins.busy !== 1'b0) begin
            n_fail++; $display("FAIL halt_hold e=%0d got=%0d/%0b/%0b exp=0/0/0", e, pins.speed, pins.enable, pins.busy);
         end
      end
      pins.halt = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         adv(1);
         es = (e >= 7) ? 1 : 0;
         ee = (e >= 3);
         n_cmp++; if (pins.speed !== 3'(es)) begin n_fail++; $display("FAIL halt_restart_speed e=%0d got=%0d exp=%0d", e, pins.speed, es); end
         n_cmp++; if (pins.enable !== ee) begin n_fail++; $display("FAIL halt_restart_enable e=%0d got=%0b exp=%0b", e, pins.enable, ee); end
      end
   endtask

   task automatic test_zero_target();
      do_reset();
      pins.run = 1'b1; pins.target = 3'd0;
      for (int e = 1; e <= 40; e++) begin
         adv(1);
         n_cmp++; if (pins.speed !== 3'd0 || pins.enable !== 1'b0 || pins.busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_target e=%0d got=%0d/%0b/%0b exp=0/0/0", e, pins.speed, pins.enable, pins.busy);
         end
      end
   endtask

   task automatic test_async_reset();
      int es;
      logic ee;
      logic found;
      pins.target = 3'd7;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         adv(1);
         if (pins.speed == 3'd4) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_fail++; $display("FAIL areset_reach4 got=%0d exp=4", pins.speed); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (pins.speed !== 3'd0) begin n_fail++; $display("FAIL areset_speed got=%0d exp=0", pins.speed); end
      n_cmp++; if (pins.enable !== 1'b0) begin n_fail++; $display("FAIL areset_enable got=%0b exp=0", pins.enable); end
      n_cmp++; if (pins.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%0b exp=0", pins.busy); end
      adv(1);
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         adv(1);
         es = (e >= 7) ? 1 : 0;
         ee = (e >= 3);
         n_cmp++; if (pins.speed !== 3'(es)) begin n_fail++; $display("FAIL areset_restart_speed e=%0d got=%0d exp=%0d", e, pins.speed, es); end
         n_cmp++; if (pins.enable !== ee) begin n_fail++; $display("FAIL areset_restart_enable e=%0d got=%0b exp=%0b", e, pins.enable, ee); end
         n_cmp++; if (pins.busy !== ee) begin n_fail++; $display("FAIL areset_restart_busy e=%0d got=%0b exp=%0b", e, pins.busy, ee); end
      end
   endtask

   task automatic test_random();
      int hold;
      logic [2:0] es;
      logic ee, eb;
      do_reset();
      for (int blk = 0; blk < 120; blk++) begin
         hold        = $urandom_range(3, 25);
         pins.run    = ($urandom_range(0, 9) < 7);
         pins.target = 3'($urandom_range(0, 7));
         pins.halt   = ($urandom_range(0, 19) == 0);
         for (int h = 0; h < hold; h++) begin
            adv(1);
            es = m_speed[2:0];
            ee = (m_mode != 0);
            eb = (m_mode == 1);
            n_cmp++; if (pins.speed !== es) begin n_fail++; $display("FAIL random_speed blk=%0d got=%0d exp=%0d", blk, pins.speed, es); end
            n_cmp++; if (pins.enable !== ee) begin n_fail++; $display("FAIL random_enable blk=%0d got=%0b exp=%0b", blk, pins.enable, ee); end
            n_cmp++; if (pins.busy !== eb) begin n_fail++; $display("FAIL random_busy blk=%0d got=%0b exp=%0b", blk, pins.busy, eb); end
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      pins.run = 1'b0; pins.target = 3'd0; pins.halt = 1'b0;
      test_reset();
      test_startup();
      test_ramp_down();
      test_reversal();
      test_halt();
      test_zero_target();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
